// File: rtl/seg7_pkg.sv
// Shared constants and the nibble-to-glyph helper for the 7-segment scanner.
// Glyphs are active-low, ordered g..a (bit6 = g, bit0 = a).
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    return SEG7_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Register-file side and pin side of the multiplexed 7-segment driver.
// master = register file / bench, slave = seg7_scan.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic                lz_suppress;
  logic [3:0]          brightness;
  logic [6:0]          segment;
  logic                dp;
  logic [DIGITS-1:0]   digit_sel;
  logic                frame_done;

  modport master (
    output value, dp_in, blank, load, lz_suppress, brightness,
    input  segment, dp, digit_sel, frame_done
  );

  modport slave (
    input  value, dp_in, blank, load, lz_suppress, brightness,
    output segment, dp, digit_sel, frame_done
  );
endinterface

// File: rtl/seg7_scan_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segment_o
);

  assign segment_o = seg7_pkg::seg7_decode(nibble_i);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for DIGITS common-anode digits: prescaler, digit
// counter, double-buffered display data, leading-zero suppression, PWM
// brightness window and registered active-low pin outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_ZERO   = IW'(0);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW:0]   WIN_ONE    = (PW+1)'(1);
  localparam logic [PW:0]   WIN_STEP   = (PW+1)'(SCAN_DIV / 16);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic                pend_valid_q, pend_valid_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fd_q, fd_d;

  logic                presc_wrap_s, boundary_s, lit_s;
  logic [PW:0]         on_len_s;
  logic [DIGITS-1:0]   supp_s;
  logic [3:0]          cur_nib_s;
  logic [6:0]          glyph_s;

  // Prescaler and digit index advance; boundary marks the end of the last slot.
  always_comb begin
    presc_wrap_s = (presc_q == PRESC_LAST);
    boundary_s   = presc_wrap_s && (idx_q == IDX_LAST);
    presc_d      = presc_q;
    idx_d        = idx_q;
    if (presc_wrap_s) begin
      presc_d = PRESC_ZERO;
      if (idx_q == IDX_LAST) begin
        idx_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Pending buffer follows load; display buffer swaps only on a frame boundary.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (boundary_s && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end else begin
      disp_val_d   = disp_val_q;
    end
    if (bus.load) begin
      pend_val_d   = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_blank_d = bus.blank;
      pend_valid_d = 1'b1;
    end else if (boundary_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Leading-zero suppression: OR-accumulate non-zero nibbles from the MSB down.
  always_comb begin
    logic nz_acc;
    nz_acc = 1'b0;
    supp_s = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_acc    = nz_acc | (|disp_val_q[4*i +: 4]);
      supp_s[i] = bus.lz_suppress && !nz_acc && (i != 0);
    end
  end

  assign cur_nib_s = disp_val_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble_i  (cur_nib_s),
    .segment_o (glyph_s)
  );

  // PWM window and next pin values; presc = 0 is always a dark gap.
  always_comb begin
    on_len_s = ((PW+1)'(bus.brightness) + WIN_ONE) * WIN_STEP;
    lit_s    = (presc_q != PRESC_ZERO) && ({1'b0, presc_q} < on_len_s);
    seg_d    = SEG_OFF;
    dp_d     = 1'b1;
    sel_d    = {DIGITS{1'b1}};
    wrap_d   = boundary_s;
    fd_d     = wrap_q;
    if (lit_s) begin
      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = (idx_q != IW'(i));
      end
      if (disp_blank_q[idx_q] || supp_s[idx_q]) begin
        seg_d = SEG_OFF;
      end else begin
        seg_d = glyph_s;
      end
      if (disp_blank_q[idx_q]) begin
        dp_d = 1'b1;
      end else begin
        dp_d = ~disp_dp_q[idx_q];
      end
    end else begin
      sel_d = {DIGITS{1'b1}};
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= PRESC_ZERO;
      idx_q   <= IDX_ZERO;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Double-buffered display data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val_q   <= {(4*DIGITS){1'b0}};
      pend_dp_q    <= {DIGITS{1'b0}};
      pend_blank_q <= {DIGITS{1'b0}};
      pend_valid_q <= 1'b0;
      disp_val_q   <= {(4*DIGITS){1'b0}};
      disp_dp_q    <= {DIGITS{1'b0}};
      disp_blank_q <= {DIGITS{1'b0}};
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  // Registered pins; frame_done is delayed one extra stage to line up with slot 0 output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      sel_q  <= {DIGITS{1'b1}};
      wrap_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.segment    = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with DIGITS = 4, SCAN_DIV = 16.
module tb_seg7_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;

  localparam logic [6:0] G0   = 7'b1000000;
  localparam logic [6:0] G1   = 7'b1111001;
  localparam logic [6:0] G2   = 7'b0100100;
  localparam logic [6:0] G3   = 7'b0110000;
  localparam logic [6:0] G4   = 7'b0011001;
  localparam logic [6:0] G5   = 7'b0010010;
  localparam logic [6:0] G6   = 7'b0000010;
  localparam logic [6:0] G7   = 7'b1111000;
  localparam logic [6:0] G8   = 7'b0000000;
  localparam logic [6:0] GA   = 7'b0001000;
  localparam logic [6:0] GF   = 7'b0001110;
  localparam logic [6:0] GOFF = 7'h7F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] cap_seg [64];
  logic       cap_dp  [64];
  logic [3:0] cap_sel [64];
  logic       cap_fd  [64];

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      step();
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: frame_done got 0 for 200 cycles, required a pulse");
    end
  endtask

  // Records 64 output cycles; entry 0 is the current (frame_done) cycle.
  task automatic capture_frame();
    for (int j = 0; j < 64; j++) begin
      if (j > 0) step();
      cap_seg[j] = bus.segment;
      cap_dp[j]  = bus.dp;
      cap_sel[j] = bus.digit_sel;
      cap_fd[j]  = bus.frame_done;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] blk);
    bus.value = v;
    bus.dp_in = dpi;
    bus.blank = blk;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      bus.value       = 16'($urandom);
      bus.dp_in       = 4'($urandom);
      bus.blank       = 4'($urandom);
      bus.load        = ~bus.load;
      bus.lz_suppress = ~bus.lz_suppress;
      bus.brightness  = 4'($urandom);
      checks++;
      if ({bus.digit_sel, bus.segment, bus.dp, bus.frame_done} !== {4'hF, GOFF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold c=%0d got sel=%b seg=%b dp=%b fd=%b required sel=1111 seg=1111111 dp=1 fd=0",
                 c, bus.digit_sel, bus.segment, bus.dp, bus.frame_done);
      end
    end
    bus.load = 1'b0; bus.value = 16'h0000; bus.dp_in = 4'h0; bus.blank = 4'h0;
    bus.lz_suppress = 1'b0; bus.brightness = 4'd15;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.digit_sel !== 4'hF) begin
      errors++;
      $display("FAIL first_gap got sel=%b required 1111", bus.digit_sel);
    end
    step();
    checks++;
    if ({bus.digit_sel, bus.segment, bus.dp} !== {4'b1110, G0, 1'b1}) begin
      errors++;
      $display("FAIL first_lit got sel=%b seg=%b dp=%b required sel=1110 seg=%b dp=1",
               bus.digit_sel, bus.segment, bus.dp, G0);
    end
  endtask

  task automatic test_full_scan();
    logic [6:0] eg [4];
    eg[0] = GF; eg[1] = GA; eg[2] = G2; eg[3] = G1;
    bus.brightness = 4'd15; bus.lz_suppress = 1'b0;
    do_load(16'h12AF, 4'h0, 4'h0);
    wait_frame(); wait_frame();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg;
      s = j / 16; p = j % 16; lit = (p >= 1);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? eg[s] : GOFF;
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_dp[j], cap_fd[j]} !== {es, eseg, 1'b1, (j == 0)}) begin
        errors++;
        $display("FAIL full_scan j=%0d got sel=%b seg=%b dp=%b fd=%b required sel=%b seg=%b dp=1 fd=%0d",
                 j, cap_sel[j], cap_seg[j], cap_dp[j], cap_fd[j], es, eseg, (j == 0));
      end
    end
    step();
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_period got fd=%b after 64 cycles required 1", bus.frame_done);
    end
  endtask

  task automatic test_lz_suppress();
    logic [6:0] eg [4]; logic ed [4];
    eg[0] = G0; eg[1] = G4; eg[2] = GOFF; eg[3] = GOFF;
    ed[0] = 1'b1; ed[1] = 1'b1; ed[2] = 1'b1; ed[3] = 1'b0;
    bus.brightness = 4'd15; bus.lz_suppress = 1'b1;
    do_load(16'h0040, 4'b1000, 4'h0);
    wait_frame(); wait_frame();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg; logic edp;
      s = j / 16; p = j % 16; lit = (p >= 1);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? eg[s] : GOFF;
      edp  = lit ? ed[s] : 1'b1;
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_dp[j]} !== {es, eseg, edp}) begin
        errors++;
        $display("FAIL lz_suppress j=%0d got sel=%b seg=%b dp=%b required sel=%b seg=%b dp=%b",
                 j, cap_sel[j], cap_seg[j], cap_dp[j], es, eseg, edp);
      end
    end
    bus.lz_suppress = 1'b0;
  endtask

  task automatic test_bright_blank();
    logic [6:0] eg [4]; logic ed [4];
    eg[0] = G0; eg[1] = GOFF; eg[2] = G2; eg[3] = G3;
    ed[0] = 1'b0; ed[1] = 1'b1; ed[2] = 1'b0; ed[3] = 1'b0;
    bus.brightness = 4'd0; bus.lz_suppress = 1'b0;
    do_load(16'h3210, 4'b1111, 4'b0010);
    wait_frame(); wait_frame();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_dp[j]} !== {4'hF, GOFF, 1'b1}) begin
        errors++;
        $display("FAIL bright0 j=%0d got sel=%b seg=%b dp=%b required all dark",
                 j, cap_sel[j], cap_seg[j], cap_dp[j]);
      end
    end
    bus.brightness = 4'd7;
    wait_frame();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg; logic edp;
      s = j / 16; p = j % 16; lit = (p >= 1) && (p <= 7);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? eg[s] : GOFF;
      edp  = lit ? ed[s] : 1'b1;
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_dp[j]} !== {es, eseg, edp}) begin
        errors++;
        $display("FAIL bright7_blank j=%0d got sel=%b seg=%b dp=%b required sel=%b seg=%b dp=%b",
                 j, cap_sel[j], cap_seg[j], cap_dp[j], es, eseg, edp);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] eg [4];
    eg[0] = G8; eg[1] = G7; eg[2] = G6; eg[3] = G5;
    bus.brightness = 4'd15;
    do_load(16'h5678, 4'h0, 4'h0);
    wait_frame(); wait_frame();
    for (int j = 1; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg;
      step();
      s = j / 16; p = j % 16; lit = (p >= 1);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? eg[s] : GOFF;
      checks++;
      if ({bus.digit_sel, bus.segment} !== {es, eseg}) begin
        errors++;
        $display("FAIL tear_old j=%0d got sel=%b seg=%b required sel=%b seg=%b",
                 j, bus.digit_sel, bus.segment, es, eseg);
      end
      if (j == 33) begin
        bus.value = 16'hAAAA;
        bus.load  = 1'b1;
      end else if (j == 34) begin
        bus.load  = 1'b0;
      end
    end
    step();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg;
      s = j / 16; p = j % 16; lit = (p >= 1);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? GA : GOFF;
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_fd[j]} !== {es, eseg, (j == 0)}) begin
        errors++;
        $display("FAIL tear_new j=%0d got sel=%b seg=%b fd=%b required sel=%b seg=%b fd=%0d",
                 j, cap_sel[j], cap_seg[j], cap_fd[j], es, eseg, (j == 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 20; c++) step();
    do_load(16'h9999, 4'hF, 4'h0);
    for (int c = 0; c < 5; c++) step();
    checks++;
    if ({bus.digit_sel, bus.segment, bus.dp} !== {4'b1101, GA, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got sel=%b seg=%b dp=%b required sel=1101 seg=%b dp=1",
               bus.digit_sel, bus.segment, bus.dp, GA);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.digit_sel, bus.segment, bus.dp, bus.frame_done} !== {4'hF, GOFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got sel=%b seg=%b dp=%b fd=%b required sel=1111 seg=1111111 dp=1 fd=0",
               bus.digit_sel, bus.segment, bus.dp, bus.frame_done);
    end
    step(); step(); step();
    rst = 1'b0;
    step(); step();
    checks++;
    if ({bus.digit_sel, bus.segment, bus.dp} !== {4'b1110, G0, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_lit got sel=%b seg=%b dp=%b required sel=1110 seg=%b dp=1",
               bus.digit_sel, bus.segment, bus.dp, G0);
    end
    wait_frame(); wait_frame();
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      int s; int p; bit lit;
      logic [3:0] es; logic [6:0] eseg;
      s = j / 16; p = j % 16; lit = (p >= 1);
      es   = lit ? ~(4'b0001 << s) : 4'hF;
      eseg = lit ? G0 : GOFF;
      checks++;
      if ({cap_sel[j], cap_seg[j], cap_dp[j]} !== {es, eseg, 1'b1}) begin
        errors++;
        $display("FAIL pend_lost j=%0d got sel=%b seg=%b dp=%b required sel=%b seg=%b dp=1",
                 j, cap_sel[j], cap_seg[j], cap_dp[j], es, eseg);
      end
    end
  endtask

  initial begin
    bus.value = 16'h0000; bus.dp_in = 4'h0; bus.blank = 4'h0;
    bus.load = 1'b0; bus.lz_suppress = 1'b0; bus.brightness = 4'd15;
    #1;
    test_reset();
    test_full_scan();
    test_lz_suppress();
    test_bright_blank();
    test_tear_free();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for a bank of common-anode 7-segment digits, generalising the single-digit hex decoder to `DIGITS` channels. It provides:

- scanning, one digit per slot;
- per-digit decimal point and blanking;
- leading-zero suppression;
- 16-level PWM brightness;
- tear-free double-buffered value updates.

It sits between the CPU/debug register file and the board's segment and anode pins. All pin outputs are registered and active-low.

## Interface
- `DIGITS`, 8: number of digits scanned; range 2..16.
- `SCAN_DIV`, 1024: clocks per digit slot; at least 16, multiple of 16.
- `clk` input, 1 bit: single system clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `value` input, 4*DIGITS bits: hex nibbles; nibble i = `value[4i+3:4i]`; digit 0 is least significant (rightmost).
- `dp_in` input, DIGITS bits: decimal point request per digit.
- `blank` input, DIGITS bits: forces digit i fully dark, including its dp.
- `load` input, 1 bit: captures `value`/`dp_in`/`blank` into the pending buffer this cycle.
- `lz_suppress` input, 1 bit: enables leading-zero suppression.
- `brightness` input, 4 bits: 0 = dimmest, 15 = brightest.
- `segment` output, 7 bits: active-low segments g..a (bit6 = g, bit0 = a).
- `dp` output, 1 bit: active-low decimal point.
- `digit_sel` output, DIGITS bits: active-low anode enables, at most one low.
- `frame_done` output, 1 bit: one-cycle pulse when the last digit slot ends.

## Operation
- **Buffers.**
  - `load` copies the inputs into the pending buffer and sets `pend_valid`.
  - At each frame boundary (end of slot DIGITS-1) with `pend_valid` set: pending is copied into the display buffer and `pend_valid` clears.
  - `load` on the boundary cycle itself: the new data goes to pending and is shown next frame, never half-frame.
- **Prescaler.** Counter `presc` runs 0..SCAN_DIV-1 and wraps.
- **Digit index.** `idx` counts 0..DIGITS-1 and increments when `presc` wraps. `idx` wraps DIGITS-1 → 0 with `frame_done` = 1.
- **On-window.** Define on_len = (brightness+1)*(SCAN_DIV/16). The slot is lit when 1 ≤ `presc` ≤ on_len-1.
  - `presc` = 0 is always dark (anti-ghosting gap).
  - `brightness` is sampled live, with no latching.
- **Suppression.** Digit i is suppressed when `lz_suppress` = 1, display nibbles i..DIGITS-1 are all zero, and i ≠ 0.
  - Digit 0 always shows.
  - A suppressed digit has dark segments but still shows `dp` per `dp_in`.
- **Output per lit cycle.**
  - `digit_sel` = ~(1 << idx).
  - `segment` = decode(nibble[idx]) unless the digit is blank or suppressed; in that case 7'h7F.
  - `dp` = ~dp_in[idx] unless blank.
- **Dark cycles.** `digit_sel` = all ones, `segment` = 7'h7F, `dp` = 1.
- **Decode glyphs**, active-low g..a:
  - 0 = 7'b1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Reset (asynchronous).**
  - `presc` = 0, `idx` = 0, both buffers = 0, `pend_valid` = 0.
  - `segment` = 7'h7F, `dp` = 1, `digit_sel` = all ones, `frame_done` = 0.
  - Reset mid-frame discards pending data.

## Timing
- **Output latency.** Outputs are registered: they reflect `presc`/`idx` of the previous cycle.
  - The first lit output appears 2 cycles after reset deassertion (`presc` reaches 1, then the register stage).
- **`frame_done` pulse.** Asserted for exactly 1 cycle, coincident with the output cycle after `idx` wraps to 0.
- **Buffer swap.** The swap is visible from the first lit cycle of slot 0 of the following frame.
- **Load-to-display latency.** Worst case is DIGITS*SCAN_DIV + 2 cycles from `load`.
- **Brightness 15.** The slot is lit for SCAN_DIV-1 cycles.
- **Brightness 0.** The slot is lit for SCAN_DIV/16-1 cycles.
- **Refresh rate.** Frame period = DIGITS*SCAN_DIV clocks.

## Structure
- **Package `seg7_pkg`.**
  - glyph constant array `SEG7_GLYPH[16]`;
  - `SEG_OFF` = 7'h7F;
  - function `seg7_decode(nibble)`.
- **Sub-module `seg7_decode`.** Combinational nibble → active-low segments, built on the package function.
- **Top `seg7_scan`.** Holds the prescaler, digit counter, double buffer, suppression logic (prefix-OR from MSB) and output registers.

## Test plan
All scenarios use DIGITS = 4, SCAN_DIV = 16.

1. **Reset hold.** Hold `rst`, toggle all inputs → `segment` = 7'h7F, `dp` = 1, `digit_sel` = 4'hF, `frame_done` = 0 throughout.
2. **Full-brightness scan.** `load` with `value` = 16'h12AF, `brightness` = 15, `lz_suppress` = 0 →
   - after the next frame boundary, slot 0 drives `digit_sel` = 4'b1110, `segment` = 7'b0001110 (F) for 15 cycles, then 1 dark cycle;
   - slot 3 drives 7'b1111001 (1);
   - `frame_done` pulses every 64 cycles.
3. **Leading-zero suppression.** `value` = 16'h0040, `lz_suppress` = 1, `dp_in` = 4'b1000 →
   - digit 3: segments 7'h7F but `dp` = 0;
   - digit 2: 7'h7F with `dp` = 1;
   - digit 1: 4 (7'b0011001);
   - digit 0: 0 (7'b1000000).
4. **Brightness and blanking.** `brightness` = 0 → each slot lit 0 cycles (on_len = 1, window empty). `brightness` = 7 → lit 7 cycles per slot. `blank` = 4'b0010 → digit 1 fully dark, including `dp`.
5. **Tear-free load.** `load` of 16'hAAAA issued mid-frame, at `idx` = 2 → digits 2 and 3 keep the old value for the rest of that frame; the new value appears from slot 0 of the next frame.
6. **Reset mid-operation.** Assert `rst` with `pend_valid` = 1 → outputs off immediately, without waiting for a clock edge. After release, the display shows 0 on digit 0; the pending data is lost.
